// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// mem_pkg
//   Shared sizing constants and FSM state encoding for the paged memory fill.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 16;
  localparam int PAGES     = 2;
  localparam int BX_W      = 2;
  localparam int ADDR_W    = $clog2(RAM_DEPTH);
  localparam int PAGE_W    = $clog2(PAGES);
  localparam int NENT_W    = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_BX = 2'd1,
    FILL    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/page_counter.sv
//------------------------------------------------------------------------------
// page_counter
//   Entry count and page index of the page being filled.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module page_counter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              advance,
  input  logic              wr,
  output logic [NENT_W-1:0] count,
  output logic              full,
  output logic [PAGE_W-1:0] page
);

  localparam logic [NENT_W-1:0] c_depth     = NENT_W'(RAM_DEPTH);
  localparam logic [NENT_W-1:0] c_cnt_one   = NENT_W'(1);
  localparam logic [PAGE_W-1:0] c_last_page = PAGE_W'(PAGES - 1);
  localparam logic [PAGE_W-1:0] c_page_one  = PAGE_W'(1);

  // A restart with wr set counts the word that opens the new page.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      page  <= '0;
    end else begin
      if (restart)
        count <= {{(NENT_W-1){1'b0}}, wr};
      else if (wr)
        count <= count + c_cnt_one;

      if (advance)
        page <= (page == c_last_page) ? '0 : page + c_page_one;
    end
  end

  assign full = (count == c_depth);

endmodule

`default_nettype wire

// File: rtl/bx_page_writer.sv
//------------------------------------------------------------------------------
// bx_page_writer
//   Writes a BX-tagged word stream into one page of a dual-page memory and
//   swaps pages, publishing the entry count, on every BX change.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bx_page_writer
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_proc,
  input  logic [BX_W-1:0]      bx_in,
  input  logic [RAM_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 wea,
  output logic [ADDR_W-1:0]    addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic [PAGE_W-1:0]    pagea,
  output logic [NENT_W-1:0]    nent,
  output logic [PAGE_W-1:0]    nent_page,
  output logic [BX_W-1:0]      bx_out,
  output logic                 done,
  output logic                 overflow
);

  state_t            r_state;
  logic [BX_W-1:0]   r_bx_q;

  logic              w_bx_chg;
  logic              w_fill;
  logic              w_start;
  logic              w_close;
  logic              w_abort;
  logic              w_wr;
  logic              w_drop;
  logic              w_full;
  logic [NENT_W-1:0] w_count;
  logic [PAGE_W-1:0] w_page;

  assign w_bx_chg = (bx_in != r_bx_q);
  assign w_fill   = (r_state == FILL) && en_proc;
  assign w_close  = w_fill && w_bx_chg;
  // A page opens on the alignment edge out of WAIT_BX or on any BX change in FILL.
  assign w_start  = w_close || ((r_state == WAIT_BX) && en_proc && w_bx_chg);
  assign w_abort  = (r_state == FILL) && !en_proc;
  assign w_wr     = din_valid && (w_start || (w_fill && !w_full));
  assign w_drop   = din_valid && w_fill && !w_bx_chg && w_full;

  page_counter u_page_counter (
    .clk     (clk),
    .reset   (reset),
    .restart (w_start || w_abort),
    .advance (w_close),
    .wr      (w_wr),
    .count   (w_count),
    .full    (w_full),
    .page    (w_page)
  );

  assign pagea = w_page;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bx_q    <= '0;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      nent      <= '0;
      nent_page <= '0;
      bx_out    <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wea  <= w_wr;
      done <= w_close;

      if (w_wr) begin
        addra <= w_start ? '0 : w_count[ADDR_W-1:0];
        dina  <= din;
      end

      if (w_close) begin
        nent      <= w_count;
        nent_page <= w_page;
        bx_out    <= r_bx_q;
      end

      if (w_start || w_abort)
        overflow <= 1'b0;
      else if (w_drop)
        overflow <= 1'b1;

      if (r_state != IDLE)
        r_bx_q <= bx_in;

      case (r_state)
        IDLE:    if (en_proc) r_state <= WAIT_BX;
        WAIT_BX: begin
          if (!en_proc)
            r_state <= IDLE;
          else if (w_bx_chg)
            r_state <= FILL;
        end
        FILL:    if (!en_proc) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bx_page_writer.sv
//------------------------------------------------------------------------------
// tb_bx_page_writer
//   Self-checking bench: vector table for the basic fill plus scripted
//   sequences for overflow, same-cycle BX change, empty BX, alignment, reset.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bx_page_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_proc;
  logic [1:0]  bx_in;
  logic [31:0] din;
  logic        din_valid;
  logic        wea;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic [0:0]  pagea;
  logic [4:0]  nent;
  logic [0:0]  nent_page;
  logic [1:0]  bx_out;
  logic        done;
  logic        overflow;

  bx_page_writer dut (
    .clk       (clk),
    .reset     (reset),
    .en_proc   (en_proc),
    .bx_in     (bx_in),
    .din       (din),
    .din_valid (din_valid),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .pagea     (pagea),
    .nent      (nent),
    .nent_page (nent_page),
    .bx_out    (bx_out),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        page;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [4:0] nent;
    logic       page;
    logic [1:0] bx;
  } dn_t;

  typedef struct {
    logic        en;
    logic [1:0]  bx;
    logic        v;
    logic [31:0] d;
    logic        e_wea;
    logic [3:0]  e_addr;
    logic        e_done;
    logic [4:0]  e_nent;
    logic [1:0]  e_bx;
  } vec_t;

  wr_t wq[$];
  dn_t dq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;

  // Reference model state
  int         m_state;
  logic [1:0] m_bxq;
  int         m_cnt;
  logic       m_page;
  logic       m_ovf;
  logic [4:0] m_nent;
  logic       m_npage;
  logic [1:0] m_bxout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_bxq = 2'd0; m_cnt = 0; m_page = 1'b0; m_ovf = 1'b0;
    m_nent = 5'd0; m_npage = 1'b0; m_bxout = 2'd0;
    wq.delete();
    dq.delete();
  endtask

  task automatic push_wr(input logic [31:0] d);
    wq.push_back(wr_t'{page: m_page, addr: 4'(m_cnt), data: d});
    m_cnt++;
  endtask

  task automatic step(input logic en, input logic [1:0] bx, input logic v, input logic [31:0] d);
    wr_t ew;
    dn_t ed;
    en_proc = en; bx_in = bx; din_valid = v; din = d;
    case (m_state)
      0: if (en) m_state = 1;
      1: begin
        if (!en) m_state = 0;
        else if (bx != m_bxq) begin
          m_state = 2; m_cnt = 0; m_ovf = 1'b0;
          if (v) push_wr(d);
        end
        m_bxq = bx;
      end
      default: begin
        if (!en) begin
          m_state = 0; m_cnt = 0; m_ovf = 1'b0;
        end else if (bx != m_bxq) begin
          dq.push_back(dn_t'{nent: 5'(m_cnt), page: m_page, bx: m_bxq});
          m_nent = 5'(m_cnt); m_npage = m_page; m_bxout = m_bxq;
          m_page = ~m_page; m_cnt = 0; m_ovf = 1'b0;
          if (v) push_wr(d);
        end else if (v) begin
          if (m_cnt < 16) push_wr(d);
          else m_ovf = 1'b1;
        end
        m_bxq = bx;
      end
    endcase
    @(posedge clk);
    #1;
    if (wea) n_writes++;
    chk("wea", wea, wq.size() != 0);
    if (wq.size() != 0) begin
      ew = wq.pop_front();
      if (wea) begin
        chk("addra", addra, ew.addr);
        chk("wr_pagea", pagea, ew.page);
        chk("dina", dina, ew.data);
      end
    end
    chk("done", done, dq.size() != 0);
    if (dq.size() != 0) ed = dq.pop_front();
    chk("nent", nent, m_nent);
    chk("nent_page", nent_page, m_npage);
    chk("bx_out", bx_out, m_bxout);
    chk("overflow", overflow, m_ovf);
    chk("pagea", pagea, m_page);
  endtask

  vec_t tbl[10];
  int   w0;

  initial begin
    tbl[0] = '{1'b1, 2'd0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 5'd0, 2'd0};
    tbl[1] = '{1'b1, 2'd0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 5'd0, 2'd0};
    tbl[2] = '{1'b1, 2'd1, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 5'd0, 2'd0};
    tbl[3] = '{1'b1, 2'd1, 1'b1, 32'hA0, 1'b1, 4'd0, 1'b0, 5'd0, 2'd0};
    tbl[4] = '{1'b1, 2'd1, 1'b1, 32'hA1, 1'b1, 4'd1, 1'b0, 5'd0, 2'd0};
    tbl[5] = '{1'b1, 2'd1, 1'b1, 32'hA2, 1'b1, 4'd2, 1'b0, 5'd0, 2'd0};
    tbl[6] = '{1'b1, 2'd1, 1'b1, 32'hA3, 1'b1, 4'd3, 1'b0, 5'd0, 2'd0};
    tbl[7] = '{1'b1, 2'd1, 1'b1, 32'hA4, 1'b1, 4'd4, 1'b0, 5'd0, 2'd0};
    tbl[8] = '{1'b1, 2'd2, 1'b0, 32'h0,  1'b0, 4'd0, 1'b1, 5'd5, 2'd1};
    tbl[9] = '{1'b1, 2'd2, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0, 5'd5, 2'd1};

    reset = 1'b1; en_proc = 1'b0; bx_in = 2'd0; din = 32'h0; din_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_pagea", pagea, 0);
    chk("rst_nent", nent, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Basic fill: five words, closed by BX change
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].bx, tbl[i].v, tbl[i].d);
      chk("t1_wea", wea, tbl[i].e_wea);
      if (tbl[i].e_wea) chk("t1_addra", addra, tbl[i].e_addr);
      chk("t1_done", done, tbl[i].e_done);
      if (tbl[i].e_done) begin
        chk("t1_nent", nent, tbl[i].e_nent);
        chk("t1_bx_out", bx_out, tbl[i].e_bx);
        chk("t1_nent_page", nent_page, 0);
      end
    end

    // Overflow: 18 words into a 16-entry page
    for (int i = 0; i < 18; i++) step(1'b1, 2'd2, 1'b1, 32'hB00 + i);
    chk("t2_overflow_set", overflow, 1);
    step(1'b1, 2'd3, 1'b0, 32'h0);
    chk("t2_nent_full", nent, 16);
    chk("t2_overflow_clr", overflow, 0);
    chk("t2_pagea", pagea, 0);

    // Word arriving in the same cycle as a BX change
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b1, 32'hC0 + i);
    step(1'b1, 2'd0, 1'b1, 32'h55);
    chk("t3_done", done, 1);
    chk("t3_nent", nent, 3);
    chk("t3_addra0", addra, 0);
    chk("t3_dina", dina, 32'h55);
    chk("t3_pagea", pagea, 1);
    step(1'b1, 2'd0, 1'b1, 32'h56);
    chk("t3_addra1", addra, 1);

    // Empty BX and tag wrap 3 -> 0
    step(1'b1, 2'd3, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b0, 32'h0);
    step(1'b1, 2'd0, 1'b0, 32'h0);
    chk("t4_done", done, 1);
    chk("t4_nent_zero", nent, 0);
    chk("t4_bx_out", bx_out, 3);
    chk("t4_pagea", pagea, 1);
    step(1'b1, 2'd0, 1'b0, 32'h0);
    chk("t4_done_single", done, 0);

    // Disable, re-enable: words before alignment are dropped
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 32'h0);
    w0 = n_writes;
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b1, 32'hD0 + i);
    chk("t5_no_writes", n_writes - w0, 0);
    step(1'b1, 2'd1, 1'b1, 32'hE0);
    chk("t5_align_addra", addra, 0);
    chk("t5_align_wea", wea, 1);
    step(1'b1, 2'd1, 1'b1, 32'hE1);
    step(1'b1, 2'd2, 1'b1, 32'hE2);
    step(1'b1, 2'd2, 1'b1, 32'hE3);
    for (int i = 0; i < 7; i++) step(1'b1, 2'd3, 1'b1, 32'hE4 + i);
    chk("t6_pre_wea", wea, 1);
    chk("t6_pre_addra", addra, 6);
    chk("t6_pre_pagea", pagea, 1);

    // Asynchronous reset mid-write
    #1 reset = 1'b1;
    #1;
    chk("t6_wea", wea, 0);
    chk("t6_addra", addra, 0);
    chk("t6_pagea", pagea, 0);
    chk("t6_nent", nent, 0);
    chk("t6_overflow", overflow, 0);
    model_reset();
    #3 reset = 1'b0;
    step(1'b1, 2'd0, 1'b0, 32'h0);
    step(1'b1, 2'd0, 1'b0, 32'h0);
    step(1'b1, 2'd1, 1'b1, 32'hF0);
    chk("t6_restart_wea", wea, 1);
    chk("t6_restart_addra", addra, 0);
    chk("t6_restart_pagea", pagea, 0);
    step(1'b1, 2'd1, 1'b0, 32'h0);
    step(1'b1, 2'd2, 1'b0, 32'h0);
    chk("t6_nent", nent, 1);
    chk("t6_bx_out", bx_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
